// File: rtl/led_chaser.sv
// LED pattern chaser: each rising edge of blink steps one of four patterns
// across the output bus, with a synchronous seed load and a wrap pulse every WIDTH steps.
module led_chaser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blink,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] leds,
    output logic             wrap
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;

    typedef enum logic [1:0] {
        MODE_ROT_LEFT  = 2'b00,
        MODE_ROT_RIGHT = 2'b01,
        MODE_BOUNCE    = 2'b10,
        MODE_FILL      = 2'b11
    } mode_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } fill_t;

    logic             blink_q;
    dir_t             dir, dir_next;
    fill_t            fill_st, fill_next;
    logic [CNT_W-1:0] step_cnt, cnt_next;
    logic [WIDTH-1:0] leds_next;
    logic             wrap_next;
    logic             step;
    logic [WIDTH-1:0] fill_val;
    logic [WIDTH-1:0] drain_val;

    // A held-high blink yields one step; blink_q tracks blink even while disabled,
    // so re-enabling during a high blink produces no step.
    assign step      = blink & ~blink_q & enable;
    assign fill_val  = {leds[WIDTH-2:0], 1'b1};
    assign drain_val = {leds[WIDTH-2:0], 1'b0};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q  <= 1'b0;
            leds     <= WIDTH'(1);
            dir      <= LEFT;
            fill_st  <= FILL;
            step_cnt <= '0;
            wrap     <= 1'b0;
        end else begin
            blink_q  <= blink;
            leds     <= leds_next;
            dir      <= dir_next;
            fill_st  <= fill_next;
            step_cnt <= cnt_next;
            wrap     <= wrap_next;
        end
    end

    // NOTE: every output of this block gets a default before any branch,
    // which is what keeps the combinational logic free of inferred latches.
    always_comb begin
        leds_next = leds;
        dir_next  = dir;
        fill_next = fill_st;
        cnt_next  = step_cnt;
        wrap_next = 1'b0;

        if (load) begin
            leds_next = seed;
            dir_next  = LEFT;
            fill_next = FILL;
            cnt_next  = '0;
        end else if (step) begin
            if (step_cnt == LAST_STEP) begin
                cnt_next  = '0;
                wrap_next = 1'b1;
            end else begin
                cnt_next = step_cnt + 1'b1;
            end

            unique case (mode_t'(mode))
                MODE_ROT_LEFT: begin
                    leds_next = {leds[WIDTH-2:0], leds[WIDTH-1]};
                end
                MODE_ROT_RIGHT: begin
                    leds_next = {leds[0], leds[WIDTH-1:1]};
                end
                MODE_BOUNCE: begin
                    // Reverse at the end bit so the lit pattern reflects off the edge.
                    if (dir == LEFT) begin
                        if (leds[WIDTH-1]) begin
                            dir_next  = RIGHT;
                            leds_next = leds >> 1;
                        end else begin
                            leds_next = leds << 1;
                        end
                    end else begin
                        if (leds[0]) begin
                            dir_next  = LEFT;
                            leds_next = leds << 1;
                        end else begin
                            leds_next = leds >> 1;
                        end
                    end
                end
                MODE_FILL: begin
                    if (fill_st == FILL) begin
                        leds_next = fill_val;
                        if (fill_val == ALL_ONES) begin
                            fill_next = DRAIN;
                        end
                    end else begin
                        leds_next = drain_val;
                        if (drain_val == '0) begin
                            fill_next = FILL;
                        end
                    end
                end
                default: begin
                    leds_next = leds;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_chaser.sv
// Directed self-checking bench for led_chaser (WIDTH = 8): reset, all four modes,
// edge detection, load priority, enable gating and asynchronous reset mid-run.
module tb_led_chaser;

    logic       clk;
    logic       rst;
    logic       blink;
    logic       enable;
    logic [1:0] mode;
    logic       load;
    logic [7:0] seed;
    logic [7:0] leds;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    led_chaser #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .blink  (blink),
        .enable (enable),
        .mode   (mode),
        .load   (load),
        .seed   (seed),
        .leds   (leds),
        .wrap   (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One single-cycle blink pulse; checks the pattern and wrap right after the
    // stepping edge, then that wrap has dropped one cycle later.
    task automatic do_step(input string tag, input logic [7:0] exp_leds, input logic exp_wrap);
        @(negedge clk) blink = 1'b1;
        @(negedge clk) blink = 1'b0;
        check({tag, " leds"}, leds, exp_leds);
        check({tag, " wrap"}, {7'd0, wrap}, {7'd0, exp_wrap});
        @(negedge clk);
        check({tag, " wrap drop"}, {7'd0, wrap}, 8'h00);
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    logic [7:0] rot_left_exp [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bounce_exp   [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                      8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_exp     [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                      8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
    logic [7:0] seed_rot_exp [8]  = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
    logic [7:0] rot_right_exp[4]  = '{8'h80, 8'h40, 8'h20, 8'h10};

    initial begin
        blink  = 1'b0;
        enable = 1'b0;
        mode   = 2'b00;
        load   = 1'b0;
        seed   = 8'h00;

        // Reset before any clock edge
        rst = 1'b1;
        #1;
        check("reset leds", leds, 8'h01);
        check("reset wrap", {7'd0, wrap}, 8'h00);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle leds", leds, 8'h01);
        check("idle wrap", {7'd0, wrap}, 8'h00);

        // Rotate left: wrap only after the 8th step
        enable = 1'b1;
        mode   = 2'b00;
        for (int i = 0; i < 8; i++) begin
            do_step($sformatf("rotl%0d", i), rot_left_exp[i], i == 7);
            @(negedge clk);
        end

        // Bounce from reset
        pulse_reset();
        check("bounce start", leds, 8'h01);
        mode = 2'b10;
        for (int i = 0; i < 15; i++) begin
            do_step($sformatf("bounce%0d", i), bounce_exp[i], i == 7);
        end

        // Fill/drain from a zero seed
        @(negedge clk) begin load = 1'b1; seed = 8'h00; end
        @(negedge clk) load = 1'b0;
        check("zero seed", leds, 8'h00);
        mode = 2'b11;
        for (int i = 0; i < 17; i++) begin
            do_step($sformatf("fill%0d", i), fill_exp[i], (i == 7) || (i == 15));
        end

        // Blink held high for 10 clocks gives exactly one step
        mode = 2'b00;
        @(negedge clk) blink = 1'b1;
        @(negedge clk);
        check("held first", leds, 8'h02);
        repeat (9) @(negedge clk);
        check("held still", leds, 8'h02);
        blink = 1'b0;
        @(negedge clk);
        check("held release", leds, 8'h02);

        // Load coincident with a blink rise: seed wins, counter restarts
        @(negedge clk) begin blink = 1'b1; load = 1'b1; seed = 8'hA5; end
        @(negedge clk) begin blink = 1'b0; load = 1'b0; end
        check("load over step", leds, 8'hA5);
        check("load wrap", {7'd0, wrap}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            do_step($sformatf("seedrot%0d", i), seed_rot_exp[i], i == 7);
        end

        // Disabled pulses are ignored
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_step($sformatf("disabled%0d", i), 8'hA5, 1'b0);
        end
        enable = 1'b1;

        // Rotate right to 10, then asynchronous reset between clock edges
        pulse_reset();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            do_step($sformatf("rotr%0d", i), rot_right_exp[i], 1'b0);
        end
        @(posedge clk);
        #2;
        rst   = 1'b1;
        blink = 1'b1;
        #1;
        check("async rst leds", leds, 8'h01);
        check("async rst wrap", {7'd0, wrap}, 8'h00);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("post rst step", leds, 8'h80);
        repeat (3) @(negedge clk);
        check("post rst hold", leds, 8'h80);
        blink = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_chaser.md
# led_chaser

Downstream consumer of the blinker stage: it takes the blinker's single-bit `blink` output and turns each rising edge into one step of an LED pattern on an output bus. The bus is sized for the tile's `uo_out`. The block has four pattern modes: rotate left, rotate right, bounce and fill/drain. It also supports a synchronous seed load and emits a one-cycle wrap pulse every `WIDTH` steps. It sits between the blinker and the top-level output mux, in the same clock domain as the counter.

## Interface
- `WIDTH`, default 8: pattern width in bits; legal range is ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `blink`  in  1  blinker output, synchronous to `clk`; each rising edge requests one step.
- `enable`  in  1  when 0, steps are ignored and the pattern freezes.
- `mode`  in  2  pattern select: 00 rotate left, 01 rotate right, 10 bounce, 11 fill/drain.
- `load`  in  1  synchronous load of `seed` into the pattern.
- `seed`  in  WIDTH  value loaded when `load` is 1.
- `leds`  out  WIDTH  current pattern, registered.
- `wrap`  out  1  registered one-cycle pulse, asserted after every `WIDTH`-th step.

Clock and reset are fixed as above: one clock, and a reset that is asynchronous and active-high.

## Operation
- Edge detect:
  - `blink_q` registers `blink` on every clock, regardless of `enable` or `load`.
  - `step = blink & ~blink_q & enable`.
  - A `blink` held high produces exactly one step.
  - Re-enabling while `blink` is high produces no step.
- Priority per clock edge:
  1. `rst`: asynchronous, overrides everything.
  2. `load`.
  3. `step`.
  4. Hold.
- `load` (with or without a coincident step):
  - `leds` ← `seed`; `dir` ← LEFT; `fill_st` ← FILL; `step_cnt` ← 0; `wrap` ← 0.
  - A coincident step is discarded.
- `step` in each mode:
  - 00, rotate left: `leds` ← {`leds[W-2:0]`, `leds[W-1]`}.
  - 01, rotate right: `leds` ← {`leds[0]`, `leds[W-1:1]`}.
  - 10, bounce, direction held in register `dir`:
    - dir LEFT and `leds[W-1]`=1: `dir` ← RIGHT and `leds` ← `leds>>1`.
    - dir LEFT otherwise: `leds` ← `leds<<1`.
    - dir RIGHT and `leds[0]`=1: `dir` ← LEFT and `leds` ← `leds<<1`.
    - dir RIGHT otherwise: `leds` ← `leds>>1`.
    - Bits shifted in are 0; an all-zero pattern stays zero.
  - 11, fill/drain, two-state FSM `fill_st`:
    - FILL: `leds` ← {`leds[W-2:0]`, 1}. If the new value is all ones, go to DRAIN.
    - DRAIN: `leds` ← {`leds[W-2:0]`, 0}. If the new value is zero, go to FILL.
- Mode changes:
  - A change takes effect on the next step.
  - `dir` and `fill_st` keep their values across mode changes.
  - Entering fill/drain while in FILL with `leds` = all ones gives a first step that stays all ones and moves to DRAIN.
- Step counter and wrap:
  - `step_cnt` is $clog2(WIDTH) bits and increments on every step in every mode.
  - On a step with `step_cnt` = WIDTH-1, it returns to 0 and `wrap` is 1 for the following cycle.
  - In all other cycles `wrap` is 0.
- Reset values:
  - `leds` = 1 (only bit 0 set); `dir` = LEFT; `fill_st` = FILL.
  - `step_cnt` = 0; `wrap` = 0; `blink_q` = 0.
  - Reset asserted mid-run clears the state immediately, without waiting for a clock.
  - After reset releases, a `blink` that is already high is seen as a rising edge at the first clock, because `blink_q` = 0.

## Timing
- Latency: `blink` first sampled high at clock edge k (with `blink_q` = 0 and `enable` = 1) → `leds` shows the new pattern after edge k. That is zero added cycles beyond the sampling edge.
- `wrap` is high for exactly the one cycle following edge k when edge k processed the WIDTH-th step.
- Minimum step spacing: 2 clocks (`blink` high for 1 cycle, then low for 1 cycle).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `rst` with no clock → `leds`=8'h01 and `wrap`=0 immediately. Release `rst`, hold `blink`=0 for 5 clocks → outputs unchanged.
- Rotate left: `mode`=00, `enable`=1, 8 single-cycle `blink` pulses spaced 4 clocks apart → `leds` sequence 02,04,08,10,20,40,80,01. `wrap`=1 for exactly the one cycle after the 8th step.
- Bounce: `mode`=10, from reset → 7 steps reach 80, step 8 gives 40, and steps 9–14 reach 01. Step 15 gives 02.
- Fill/drain: `load`=1 with `seed`=00, then `mode`=11 → steps give 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00,01.
- Edge detect and priority:
  - `blink` held high for 10 clocks → exactly one step.
  - `load`=1 with `seed`=8'hA5 on the same edge as a `blink` rise → `leds`=A5 with no shift, and `step_cnt` is reset (`wrap` next fires after 8 further steps).
  - `enable`=0 during 3 pulses → `leds` unchanged.
- Reset mid-run: rotate right until `leds`=10, then pulse `rst` between clock edges → `leds`=01 immediately. A `blink` already high when reset releases → one step, giving `leds`=80 in mode 01.
